// File: rtl/unidade_busca.sv
// Instruction fetch unit: walks a fetch pointer through a synchronous-read
// instruction memory, two cycles per word, with stall, redirect and program load.
module unidade_busca #(
  parameter int unsigned LAST_ADDR   = 15,
  parameter bit          HALT_ON_NOP = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [3:0]  RedirectAddr,
  input  logic        Load_En,
  input  logic [3:0]  Load_Addr,
  input  logic [15:0] Load_Data,
  output logic [3:0]  Mem_Address,
  output logic        Mem_Wren,
  output logic [15:0] Mem_Din,
  input  logic [15:0] Mem_Q,
  output logic [15:0] IR,
  output logic [3:0]  PC,
  output logic        Valid,
  output logic        Halted,
  output logic [7:0]  Count,
  output logic [2:0]  Opcode,
  output logic [2:0]  Rx,
  output logic [2:0]  Ry,
  output logic [2:0]  Rz,
  output logic [6:0]  Imm7,
  output logic [3:0]  Imm4
);

  localparam logic [3:0] LAST = 4'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HALT} state_t;

  state_t     state, state_nxt;
  logic [3:0] fp, fp_nxt;
  logic       capture;

  always_comb begin
    state_nxt = state;
    fp_nxt    = fp;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // A load cycle swallows both Redirect and Start.
        if (!Load_En) begin
          if (Redirect)   fp_nxt    = RedirectAddr;
          else if (Start) state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (Redirect)    fp_nxt    = RedirectAddr;
        else if (!Stall) state_nxt = LATCH;
      end
      LATCH: begin
        if (Redirect) begin
          fp_nxt    = RedirectAddr;
          state_nxt = FETCH;
        end else if (HALT_ON_NOP && Mem_Q == '0) begin
          state_nxt = HALT;
        end else begin
          capture   = 1'b1;
          fp_nxt    = (fp == LAST) ? '0 : fp + 4'd1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        if (Redirect) begin
          fp_nxt    = RedirectAddr;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      fp    <= '0;
      IR    <= '0;
      PC    <= '0;
      Valid <= 1'b0;
      Count <= '0;
    end else begin
      state <= state_nxt;
      fp    <= fp_nxt;
      Valid <= capture;
      if (capture) begin
        IR <= Mem_Q;
        PC <= fp;
        if (Count != '1) Count <= Count + 8'd1;
      end
    end
  end

  always_comb begin
    Mem_Wren    = (state == IDLE) && Load_En && !Reset;
    Mem_Address = (state == IDLE) ? Load_Addr : fp;
    Mem_Din     = (state == IDLE) ? Load_Data : '0;
    Halted      = (state == HALT);
  end

  assign Opcode = IR[15:13];
  assign Rx     = IR[12:10];
  assign Ry     = IR[9:7];
  assign Rz     = IR[6:4];
  assign Imm7   = IR[6:0];
  assign Imm4   = IR[3:0];

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios plus randomized programs/stalls
// checked against a program-walk model of the expected (PC, IR) stream.
module tb_unidade_busca;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        rst, start, stall, redir, ld_en;
  logic [3:0]  redir_addr, ld_addr, maddr, pc;
  logic [15:0] ld_data, mdin, mq, ir;
  logic        mwren, valid, halted;
  logic [7:0]  count;
  logic [2:0]  opc, rx, ry, rz;
  logic [6:0]  imm7;
  logic [3:0]  imm4;

  logic        rst1, start1, stall1, redir1, ld_en1;
  logic [3:0]  redir_addr1, ld_addr1, maddr1, pc1;
  logic [15:0] ld_data1, mdin1, mq1, ir1;
  logic        mwren1, valid1, halted1;
  logic [7:0]  count1;
  logic [2:0]  opc1, rx1, ry1, rz1;
  logic [6:0]  imm71;
  logic [3:0]  imm41;

  unidade_busca u0 (
    .Clock(Clock), .Reset(rst), .Start(start), .Stall(stall),
    .Redirect(redir), .RedirectAddr(redir_addr),
    .Load_En(ld_en), .Load_Addr(ld_addr), .Load_Data(ld_data),
    .Mem_Address(maddr), .Mem_Wren(mwren), .Mem_Din(mdin), .Mem_Q(mq),
    .IR(ir), .PC(pc), .Valid(valid), .Halted(halted), .Count(count),
    .Opcode(opc), .Rx(rx), .Ry(ry), .Rz(rz), .Imm7(imm7), .Imm4(imm4)
  );

  unidade_busca #(.LAST_ADDR(3), .HALT_ON_NOP(1'b0)) u1 (
    .Clock(Clock), .Reset(rst1), .Start(start1), .Stall(stall1),
    .Redirect(redir1), .RedirectAddr(redir_addr1),
    .Load_En(ld_en1), .Load_Addr(ld_addr1), .Load_Data(ld_data1),
    .Mem_Address(maddr1), .Mem_Wren(mwren1), .Mem_Din(mdin1), .Mem_Q(mq1),
    .IR(ir1), .PC(pc1), .Valid(valid1), .Halted(halted1), .Count(count1),
    .Opcode(opc1), .Rx(rx1), .Ry(ry1), .Rz(rz1), .Imm7(imm71), .Imm4(imm41)
  );

  // Synchronous-read instruction memories (read-before-write).
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  always @(posedge Clock) begin
    if (mwren) mem0[maddr] <= mdin;
    mq <= mem0[maddr];
  end
  always @(posedge Clock) begin
    if (mwren1) mem1[maddr1] <= mdin1;
    mq1 <= mem1[maddr1];
  end

  logic [15:0] dflt [16] = '{16'h8882, 16'hA081, 16'h40A0, 16'h6112,
                             16'h2224, 16'hC3C5, 16'h1F0F, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] model  [16];
  logic [15:0] model1 [4];
  logic [19:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic wait_valid(input bit inst, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(inst ? valid1 : valid) && n < bound);
    chk("wait_valid", inst ? valid1 : valid, 1);
  endtask

  task automatic load(input bit inst, input bit noise);
    for (int unsigned a = 0; a < (inst ? 4 : 16); a++) begin
      if (inst) begin
        ld_en1 = 1'b1; ld_addr1 = 4'(a); ld_data1 = model1[a];
      end else begin
        ld_en = 1'b1; ld_addr = 4'(a); ld_data = model[a];
        if (noise) start = 1'($urandom_range(0, 1));
      end
      step();
    end
    ld_en = 1'b0; ld_en1 = 1'b0; start = 1'b0;
  endtask

  // Expected stream: walk from s, wrapping 15->0, until a zero word.
  task automatic build_exp(input logic [3:0] s, output logic [3:0] last, output int n);
    logic [3:0] a = s;
    exp_q.delete();
    last = '0;
    n = 0;
    while (model[a] != 16'h0 && n < 16) begin
      exp_q.push_back({a, model[a]});
      last = a;
      n++;
      a = a + 4'd1;
    end
  endtask

  task automatic run0(input int bound, input bit rnd, output int npulse);
    int n = 0;
    logic [19:0] e;
    npulse = 0;
    while (!halted && n < bound) begin
      if (rnd) begin
        stall = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      step();
      n++;
      if (valid) begin
        npulse++;
        if (exp_q.size() == 0) chk("extra_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("stream_pc", pc, e[19:16]);
          chk("stream_ir", ir, e[15:0]);
        end
      end
    end
    stall = 1'b0; start = 1'b0;
    chk("halt_reached", halted, 1);
    chk("all_delivered", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] last, s;
    int         n, np, p;

    {start, stall, redir, ld_en, start1, stall1, redir1, ld_en1} = '0;
    {redir_addr, ld_addr, redir_addr1, ld_addr1} = '0;
    {ld_data, ld_data1} = '0;

    // Reset: Mem_Wren suppressed even with Load_En high.
    rst = 1'b1; rst1 = 1'b1; ld_en = 1'b1;
    #1 chk("wren_in_reset", mwren, 0);
    step(); step();
    chk("rst_ir", ir, 0);
    chk("rst_pc", pc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", count, 0);
    ld_en = 1'b0; rst = 1'b0; rst1 = 1'b0;
    for (int unsigned a = 0; a < 16; a++) model[a] = dflt[a];
    load(1'b0, 1'b0);

    // Start at E0; first word at E2, then every two edges.
    start = 1'b1; step(); start = 1'b0;
    ld_en = 1'b1;
    step();
    chk("e1_valid", valid, 0);
    chk("e1_addr_fp", maddr, 0);
    chk("e1_wren", mwren, 0);
    chk("e1_din", mdin, 0);
    ld_en = 1'b0;
    step();
    chk("e2_valid", valid, 1);
    chk("e2_ir", ir, 16'h8882);
    chk("e2_pc", pc, 0);
    chk("e2_opcode", opc, 4);
    chk("e2_rx", rx, 2);
    chk("e2_ry", ry, 1);
    chk("e2_rz", rz, 0);
    chk("e2_imm7", imm7, 2);
    chk("e2_imm4", imm4, 2);
    step();
    chk("e3_valid", valid, 0);
    step();
    chk("e4_ir", ir, 16'hA081);
    chk("e4_pc", pc, 1);
    step(); step();
    chk("e6_ir", ir, 16'h40A0);
    chk("e6_pc", pc, 2);
    build_exp(4'd3, last, n);
    run0(60, 1'b0, np);
    chk("done_pulses", np, 4);
    chk("done_count", count, 7);
    chk("done_pc", pc, 6);

    // HALT ignores Start and Stall; Redirect resumes.
    start = 1'b1; stall = 1'b1;
    step(); step();
    chk("halt_hold", halted, 1);
    chk("halt_novalid", valid, 0);
    start = 1'b0; stall = 1'b0;
    redir = 1'b1; redir_addr = 4'd3;
    step();
    redir = 1'b0;
    chk("halt_left", halted, 0);
    chk("halt_redir_novalid", valid, 0);
    build_exp(4'd3, last, n);
    run0(60, 1'b0, np);
    chk("redir_halt_count", count, 11);

    // Stall after the first word.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_valid(1'b0, 10);
    chk("stall_first_ir", ir, 16'h8882);
    stall = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("stall_novalid", valid, 0);
    end
    chk("stall_ir_held", ir, 16'h8882);
    stall = 1'b0;
    wait_valid(1'b0, 10);
    chk("stall_next_ir", ir, 16'hA081);
    chk("stall_next_pc", pc, 1);

    // Redirect during LATCH of PC=1.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("rl_e2_valid", valid, 1);
    step();
    redir = 1'b1; redir_addr = 4'd5;
    step();
    redir = 1'b0;
    chk("rl_novalid", valid, 0);
    wait_valid(1'b0, 10);
    chk("rl_pc", pc, 5);
    chk("rl_ir", ir, dflt[5]);

    // Redirect in IDLE only moves the pointer.
    rst = 1'b1; step(); rst = 1'b0;
    ld_data = 16'hBEEF;
    redir = 1'b1; redir_addr = 4'd2;
    step();
    redir = 1'b0;
    #1 chk("ri_still_idle", mdin, 16'hBEEF);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(1'b0, 10);
    chk("ri_pc", pc, 2);
    chk("ri_ir", ir, 16'h40A0);

    // Load beats Start in IDLE.
    rst = 1'b1; step(); rst = 1'b0;
    ld_en = 1'b1; ld_addr = 4'd7; ld_data = 16'h4020; start = 1'b1;
    #1 chk("ld_wren", mwren, 1);
    chk("ld_addr", maddr, 7);
    chk("ld_din", mdin, 16'h4020);
    step();
    model[7] = 16'h4020;
    ld_en = 1'b0; start = 1'b0; ld_data = 16'h1234;
    #1 chk("ld_start_ignored", mdin, 16'h1234);
    start = 1'b1; step(); start = 1'b0;
    build_exp(4'd0, last, n);
    run0(60, 1'b0, np);
    chk("ld_count", count, 8);
    chk("ld_pc", pc, 7);

    // Randomized programs, start points and stall patterns.
    for (int unsigned it = 0; it < 4; it++) begin
      rst = 1'b1; step(); rst = 1'b0;
      p = $urandom_range(0, 15);
      for (int unsigned a = 0; a < 16; a++)
        model[a] = ($urandom_range(0, 7) == 0 || a == p) ? 16'h0 : 16'($urandom_range(1, 65535));
      load(1'b0, 1'b1);
      s = 4'($urandom_range(0, 15));
      redir = 1'b1; redir_addr = s; step(); redir = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      build_exp(s, last, n);
      run0(300, 1'b1, np);
      chk("rnd_pulses", np, n);
      chk("rnd_count", count, n);
      chk("rnd_pc", pc, last);
    end

    // Count saturation on a program with no zero word.
    rst = 1'b1; step(); rst = 1'b0;
    for (int unsigned a = 0; a < 16; a++) model[a] = 16'h8000 | 16'(a);
    load(1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    p = 0; n = 0;
    while (p < 256 && n < 800) begin
      step();
      n++;
      if (valid) begin
        p++;
        if (p == 200) chk("count_200", count, 200);
      end
    end
    chk("sat_pulses", p, 256);
    chk("count_sat", count, 255);

    // Wrapping instance without halt-on-zero; reset mid-FETCH.
    model1[0] = 16'h1111; model1[1] = 16'h0000;
    model1[2] = 16'h3333; model1[3] = 16'h4444;
    load(1'b1, 1'b0);
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_valid(1'b1, 10);
    rst1 = 1'b1; ld_en1 = 1'b1;
    step();
    #1 chk("u1_wren_in_reset", mwren1, 0);
    step();
    chk("u1_rst_ir", ir1, 0);
    chk("u1_rst_count", count1, 0);
    chk("u1_rst_pc", pc1, 0);
    chk("u1_rst_valid", valid1, 0);
    rst1 = 1'b0; ld_en1 = 1'b0;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      wait_valid(1'b1, 10);
      chk("u1_pc", pc1, k % 4);
      chk("u1_ir", ir1, model1[k % 4]);
    end
    chk("u1_count", count1, 6);
    chk("u1_not_halted", halted1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
